// File: rtl/i1_capture_fifo.sv
// ----------------------------------------------------------------------------
// i1_capture_fifo
//
// Capture stage behind the i1 combinational decode block. The 16 decode
// outputs are sampled as one packed word. Each accepted word is tagged with a
// free-running cycle timestamp and buffered in a small circular FIFO. The FIFO
// is drained through a valid/ready handshake.
//
// Optional feature (macro I1_CAP_CHANGE_ONLY_EN):
//   When the macro is defined, a word is pushed only if it is the first one
//   after reset or if it differs from the last accepted word. Only transitions
//   of the decode outputs are logged. When the macro is undefined, every
//   in_valid cycle pushes.
//
// Parameters:
//   DEPTH  FIFO entries (power of two, >= 2)
//   TS_W   timestamp width
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   in_word is meaningful this cycle
//   in_word    packed i1 outputs {V38_0, V30_0, V28_0, V37_0, V27_0..V27_4,
//              V36_0, V35_0, V34_0, V33_0, V32_0, V31_0, V29_0}
//   out_valid  FIFO head is valid
//   out_ready  consumer takes the head this cycle
//   out_word   head word (0 while empty)
//   out_ts     head timestamp (0 while empty)
//   count      occupancy, 0..DEPTH
//   overflow   sticky: a push was dropped because the FIFO was full
//   clr_ovf    clears overflow (a simultaneous drop wins)
// ----------------------------------------------------------------------------
module i1_capture_fifo #(
    parameter int DEPTH = 4,
    parameter int TS_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [15:0]              in_word,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [15:0]              out_word,
    output logic [TS_W-1:0]          out_ts,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    input  logic                     clr_ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    // State
    logic [TS_W-1:0] ts_q,  ts_d;
    logic [AW-1:0]   wp_q,  wp_d;
    logic [AW-1:0]   rp_q,  rp_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ovf_q, ovf_d;

    logic [15:0]     word_mem [DEPTH];
    logic [TS_W-1:0] tag_mem  [DEPTH];

    // Control
    logic accept;
    logic push_req;
    logic full;
    logic pop;
    logic do_push;
    logic drop;

`ifdef I1_CAP_CHANGE_ONLY_EN
    logic        first_q, first_d;
    logic [15:0] last_q,  last_d;

    assign accept = first_q | (in_word != last_q);

    always_comb begin
        first_d = first_q;
        last_d  = last_q;
        // Only an accepted push moves the reference; dropped words do not.
        if (do_push) begin
            first_d = 1'b0;
            last_d  = in_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            first_q <= 1'b1;
            last_q  <= 16'h0000;
        end else begin
            first_q <= first_d;
            last_q  <= last_d;
        end
    end
`else
    assign accept = 1'b1;
`endif

    assign push_req = in_valid & accept;
    assign full     = (cnt_q == FULL_CNT);
    // A reset cycle never reports a head, so it can never report a pop.
    assign out_valid = (cnt_q != '0) & ~rst;
    assign pop       = out_valid & out_ready;
    // When full, a same-cycle pop frees the slot the push needs.
    assign do_push   = push_req & (~full | pop);
    assign drop      = push_req & full & ~pop;

    always_comb begin
        ts_d  = ts_q + 1'b1;
        wp_d  = wp_q;
        rp_d  = rp_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;

        if (do_push) wp_d = wp_q + 1'b1;   // AW-bit pointers wrap modulo DEPTH
        if (pop)     rp_d = rp_q + 1'b1;

        case ({do_push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase

        // Set has priority over clear.
        if (drop)         ovf_d = 1'b1;
        else if (clr_ovf) ovf_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ts_q  <= '0;
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            ts_q  <= ts_d;
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    // Storage needs no reset: entries are only read while counted valid.
    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            word_mem[wp_q] <= in_word;
            tag_mem[wp_q]  <= ts_q;
        end
    end

    assign out_word = out_valid ? word_mem[rp_q] : 16'h0000;
    assign out_ts   = out_valid ? tag_mem[rp_q]  : '0;
    assign count    = cnt_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_i1_capture_fifo.sv
// ----------------------------------------------------------------------------
// Bench for i1_capture_fifo (DEPTH=4, TS_W=8). A queue-based reference model
// tracks the entries, the cycle timestamp and the sticky overflow flag.
// Define I1_CAP_CHANGE_ONLY_EN for both files to exercise change-only capture.
// ----------------------------------------------------------------------------
module tb_i1_capture_fifo;

    localparam int DEPTH = 4;
    localparam int TS_W  = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic [15:0]       in_word = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [15:0]       out_word;
    logic [TS_W-1:0]   out_ts;
    logic [2:0]        count;
    logic              overflow;
    logic              clr_ovf = 1'b0;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [15+TS_W:0] mq[$];   // {word, ts}
    int               mts;
    bit               movf;
    bit               mfirst;
    logic [15:0]      mlast;

    i1_capture_fifo #(.DEPTH(DEPTH), .TS_W(TS_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_word(in_word),
        .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
        .out_ts(out_ts), .count(count), .overflow(overflow), .clr_ovf(clr_ovf)
    );

    always #5 clk = ~clk;

    task automatic model_step(input logic r, v, input logic [15:0] w, input logic rd, c);
        bit acc;
        int pre;
        if (r) begin
            mq.delete();
            mts = 0; movf = 0; mfirst = 1; mlast = '0;
            return;
        end
`ifdef I1_CAP_CHANGE_ONLY_EN
        acc = mfirst || (w != mlast);
`else
        acc = 1;
`endif
        pre = mq.size();
        if (pre > 0 && rd) void'(mq.pop_front());
        if (v && acc) begin
            if (pre < DEPTH || (pre > 0 && rd)) begin
                mq.push_back({w, TS_W'(mts)});
                mfirst = 0; mlast = w;
            end else begin
                movf = 1;
            end
        end else if (c) begin
            movf = 0;
        end
        if (v && acc && pre == DEPTH && !rd) movf = 1;
        else if (c && !(v && acc && pre == DEPTH && !rd)) movf = 0;
        mts = (mts + 1) % (1 << TS_W);
    endtask

    // Drive one cycle, advance the model, sample 1 time unit after the edge.
    task automatic cyc(input logic r, v, input logic [15:0] w, input logic rd, c);
        rst = r; in_valid = v; in_word = w; out_ready = rd; clr_ovf = c;
        model_step(r, v, w, rd, c);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        cyc(1, 0, 0, 0, 0);
        cyc(1, 1, 16'hFFFF, 1, 0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", out_valid); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %0b want 0", overflow); end
        checks++; if (out_word !== 16'h0 || out_ts !== 8'h0) begin errors++; $display("FAIL reset_head got %h/%h want 0/0", out_word, out_ts); end
    endtask

    task automatic test_first_push();
        // Reset is released; cycles 0..2 idle, push in cycle 3.
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 16'h8001, 0, 0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL first_valid got %0b want 1", out_valid); end
        checks++; if (out_word !== 16'h8001) begin errors++; $display("FAIL first_word got %h want 8001", out_word); end
        checks++; if (out_ts !== 8'd3) begin errors++; $display("FAIL first_ts got %0d want 3", out_ts); end
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL first_count got %0d want 1", count); end
        cyc(0, 0, 0, 1, 0);
        checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL first_drain got %0d/%0b want 0/0", count, out_valid); end
    endtask

    task automatic test_overflow();
        logic [7:0] exp_ts [4];
        for (int k = 1; k <= 5; k++) begin
            if (k <= 4) exp_ts[k-1] = 8'(mts);
            cyc(0, 1, 16'h1111 * k[15:0], 0, 0);
        end
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL ovf_count got %0d want 4", count); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %0b want 1", overflow); end
        for (int k = 1; k <= 4; k++) begin
            checks++;
            if (out_valid !== 1'b1 || out_word !== 16'h1111 * k[15:0] || out_ts !== exp_ts[k-1]) begin
                errors++;
                $display("FAIL ovf_drain%0d got %b/%h/%0d want 1/%h/%0d", k, out_valid, out_word, out_ts, 16'h1111 * k[15:0], exp_ts[k-1]);
            end
            cyc(0, 0, 0, 1, 0);
        end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL ovf_empty got %0d want 0", count); end
    endtask

    task automatic test_full_pushpop();
        cyc(0, 0, 0, 0, 1);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fpp_clr got %0b want 0", overflow); end
        for (int k = 1; k <= 4; k++) cyc(0, 1, 16'hA000 + k[15:0], 0, 0);
        cyc(0, 1, 16'hBEEF, 1, 0);
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL fpp_count got %0d want 4", count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fpp_ovf got %0b want 0", overflow); end
        for (int k = 2; k <= 5; k++) begin
            logic [15:0] ew;
            ew = (k == 5) ? 16'hBEEF : 16'hA000 + k[15:0];
            checks++; if (out_word !== ew) begin errors++; $display("FAIL fpp_drain%0d got %h want %h", k, out_word, ew); end
            cyc(0, 0, 0, 1, 0);
        end
    endtask

    task automatic test_ovf_clr();
        for (int k = 1; k <= 4; k++) cyc(0, 1, 16'hC000 + k[15:0], 0, 0);
        cyc(0, 1, 16'hD001, 0, 0);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL oc_set got %0b want 1", overflow); end
        cyc(0, 1, 16'hD002, 0, 1);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL oc_setwins got %0b want 1", overflow); end
        cyc(0, 0, 0, 0, 1);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL oc_clear got %0b want 0", overflow); end
        for (int k = 0; k < 4; k++) cyc(0, 0, 0, 1, 0);
    endtask

    task automatic test_change_only();
        logic [15:0] seq [6] = '{16'd5, 16'd5, 16'd5, 16'd7, 16'd7, 16'd5};
        logic [15:0] got [$];
        int exp_n;
        cyc(1, 0, 0, 0, 0);
        for (int k = 0; k < 6; k++) begin
            if (out_valid) got.push_back(out_word);
            cyc(0, 1, seq[k], 1, 0);
        end
        for (int k = 0; k < 8; k++) begin
            if (out_valid) got.push_back(out_word);
            cyc(0, 0, 0, 1, 0);
        end
`ifdef I1_CAP_CHANGE_ONLY_EN
        exp_n = 3;
`else
        exp_n = 6;
`endif
        checks++; if (got.size() != exp_n) begin errors++; $display("FAIL chg_count got %0d want %0d", got.size(), exp_n); end
        for (int k = 0; k < got.size() && k < exp_n; k++) begin
            logic [15:0] ew;
            ew = (exp_n == 3) ? ((k == 1) ? 16'd7 : 16'd5) : seq[k];
            checks++; if (got[k] !== ew) begin errors++; $display("FAIL chg_word%0d got %0d want %0d", k, got[k], ew); end
        end
    endtask

    task automatic test_ts_wrap();
        cyc(1, 0, 0, 0, 0);
        for (int k = 0; k < 255; k++) cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 16'hAAAA, 0, 0);   // cycle 255
        cyc(0, 1, 16'h5555, 0, 0);   // cycle 256
        checks++; if (count !== 3'd2 || out_ts !== 8'd255) begin errors++; $display("FAIL wrap_first got %0d/%0d want 2/255", count, out_ts); end
        cyc(0, 1, 16'h1234, 1, 0);
        checks++; if (out_ts !== 8'd0 || out_word !== 16'h5555) begin errors++; $display("FAIL wrap_second got %0d/%h want 0/5555", out_ts, out_word); end
        cyc(0, 1, 16'h4321, 0, 0);
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL wrap_three got %0d want 3", count); end
        cyc(1, 1, 16'h9999, 1, 0);
        checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL midrst got %0d/%0b want 0/0", count, out_valid); end
        cyc(0, 0, 0, 0, 0);
        checks++; if (count !== 3'd0 || out_valid !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL midrst_after got %0d/%0b/%0b want 0/0/0", count, out_valid, overflow); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 3000; n++) begin
            logic [15:0] w;
            logic [15:0] ew;
            logic [7:0]  et;
            w = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 3));
            cyc(($urandom_range(0, 127) == 0), ($urandom_range(0, 3) != 0), w,
                ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0));
            ew = (mq.size() != 0) ? mq[0][15+TS_W:TS_W] : 16'h0;
            et = (mq.size() != 0) ? mq[0][TS_W-1:0] : 8'h0;
            checks++;
            if (out_valid !== (mq.size() != 0) || count !== 3'(mq.size()) || out_word !== ew ||
                out_ts !== et || overflow !== movf) begin
                errors++;
                $display("FAIL rand%0d got v%0b c%0d w%h t%0d o%0b want v%0b c%0d w%h t%0d o%0b",
                         n, out_valid, count, out_word, out_ts, overflow,
                         (mq.size() != 0), mq.size(), ew, et, movf);
            end
        end
    endtask

    initial begin
        mts = 0; movf = 0; mfirst = 1; mlast = '0;
        #1;
        test_reset();
        test_first_push();
        test_overflow();
        test_full_pushpop();
        test_ovf_clr();
        test_change_only();
        test_ts_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
